// File: rtl/beat_sequencer.sv
// beat_sequencer
//  Instruction-level controller for the CPU beat generator. Owns the one-hot
//  beat ring and steps it through FETCH, EXEC and INTR machine cycles. Handles
//  start/stop, halt at an instruction boundary, single-step, early cycle end
//  from the decoder, and interrupt entry. All outputs are registered.
//
//  Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   run_i         start continuous execution (looked at in STOP only)
//   step_i        execute one instruction (looked at in STOP only)
//   halt_i        stop request, honoured at the next instruction boundary
//   need_exec_i   decoder: instruction needs an EXEC cycle (looked at FETCH end)
//   cyc_end_i     decoder: current beat is the last of this FETCH/EXEC cycle
//   irq_i         interrupt request level, looked at on instruction boundary
//   beat_o        one-hot beat, T0 = bit 0, zero in STOP
//   mcyc_o        machine cycle: 0 STOP, 1 FETCH, 2 EXEC, 3 INTR
//   irq_ack_o     one-cycle pulse on the first beat of INTR
//   instr_done_o  one-cycle pulse in the cycle after an instruction's last beat
//   running_o     high whenever mcyc_o != STOP
//
//  state    | meaning
//  ST_STOP  | idle, beat ring cleared, waiting for run/step
//  ST_FETCH | instruction fetch machine cycle
//  ST_EXEC  | execute machine cycle, only when the decoder asked for it
//  ST_INTR  | interrupt entry cycle, always a full NBEATS beats

module beat_sequencer #(
   parameter int NBEATS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_i,
   input  logic              step_i,
   input  logic              halt_i,
   input  logic              need_exec_i,
   input  logic              cyc_end_i,
   input  logic              irq_i,
   output logic [NBEATS-1:0] beat_o,
   output logic [1:0]        mcyc_o,
   output logic              irq_ack_o,
   output logic              instr_done_o,
   output logic              running_o
);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_INTR  = 2'd3
   } state_t;

   localparam logic [NBEATS-1:0] BEAT_T0 = {{(NBEATS-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [NBEATS-1:0] beat_q, beat_d;
   logic              irq_ack_q, irq_ack_d;
   logic              instr_done_q, instr_done_d;
   logic              running_q, running_d;
   logic              halt_pend_q, halt_pend_d;
   logic              step_mode_q, step_mode_d;

   logic              cend;
   logic              halt_any;
   logic              boundary;
   logic [NBEATS-1:0] beat_rot;

   // The decoder's early end only applies to FETCH/EXEC; INTR always runs full length.
   assign cend     = beat_q[NBEATS-1]
                   | (cyc_end_i & ((state_q == ST_FETCH) | (state_q == ST_EXEC)));
   assign halt_any = halt_pend_q | halt_i;
   assign beat_rot = {beat_q[NBEATS-2:0], beat_q[NBEATS-1]};

   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      irq_ack_d    = 1'b0;
      instr_done_d = 1'b0;
      halt_pend_d  = halt_pend_q;
      step_mode_d  = step_mode_q;
      boundary     = 1'b0;

      unique case (state_q)
         ST_STOP: begin
            beat_d = '0;
            // halt outranks run/step; run outranks step
            if (!halt_i) begin
               if (run_i) begin
                  state_d     = ST_FETCH;
                  beat_d      = BEAT_T0;
                  step_mode_d = 1'b0;
               end else if (step_i) begin
                  state_d     = ST_FETCH;
                  beat_d      = BEAT_T0;
                  step_mode_d = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            if (!cend) begin
               beat_d = beat_rot;
            end else if (need_exec_i) begin
               state_d = ST_EXEC;
               beat_d  = BEAT_T0;
            end else begin
               boundary = 1'b1;
            end
         end
         ST_EXEC: begin
            if (!cend) beat_d = beat_rot;
            else       boundary = 1'b1;
         end
         ST_INTR: begin
            if (!cend) begin
               beat_d = beat_rot;
            end else if (halt_any) begin
               state_d = ST_STOP;
               beat_d  = '0;
            end else begin
               state_d = ST_FETCH;
               beat_d  = BEAT_T0;
            end
         end
         default: begin
            state_d = ST_STOP;
            beat_d  = '0;
         end
      endcase

      if (state_q != ST_STOP) halt_pend_d = halt_any;

      if (boundary) begin
         instr_done_d = 1'b1;
         if (halt_any | step_mode_q) begin
            state_d = ST_STOP;
            beat_d  = '0;
         end else if (irq_i) begin
            state_d   = ST_INTR;
            beat_d    = BEAT_T0;
            irq_ack_d = 1'b1;
         end else begin
            state_d = ST_FETCH;
            beat_d  = BEAT_T0;
         end
      end

      // A pending halt is consumed by the act of stopping.
      if (state_d == ST_STOP) halt_pend_d = 1'b0;
   end

   assign running_d = (state_d != ST_STOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_STOP;
         beat_q       <= '0;
         irq_ack_q    <= 1'b0;
         instr_done_q <= 1'b0;
         running_q    <= 1'b0;
         halt_pend_q  <= 1'b0;
         step_mode_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         irq_ack_q    <= irq_ack_d;
         instr_done_q <= instr_done_d;
         running_q    <= running_d;
         halt_pend_q  <= halt_pend_d;
         step_mode_q  <= step_mode_d;
      end
   end

   assign beat_o       = beat_q;
   assign mcyc_o       = state_q;
   assign irq_ack_o    = irq_ack_q;
   assign instr_done_o = instr_done_q;
   assign running_o    = running_q;

endmodule
